ks_pluck_ctrl: RTL and testbench
================================

KS_PLUCK_CTRL -- requirements
Module: ks_pluck_ctrl

Interface
REQ-001 SHALL have parameter LINE_LEN, default 700: number of delay-line words loaded per pluck.
REQ-002 SHALL have parameter PULSE_HI, default 2: clk cycles noise_pulse stays high per pulse.
REQ-003 SHALL have parameter PULSE_LO, default 2: clk cycles noise_pulse stays low per pulse.
REQ-004 SHALL have parameter GUARD, default 4: clk cycles noise_en stays high after the last pulse.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 pluck_valid  input  1  pluck request.
REQ-008 pluck_ready  output  1  request accepted when valid and ready are both high on a clk edge.
REQ-009 pluck_sel  input  10  note tap select captured on accept.
REQ-010 pluck_div  input  32  pitch divider value captured on accept.
REQ-011 pluck_amp  input  2  attenuation: noise = LFSR arithmetic-shifted right by pluck_amp.
REQ-012 noise  output  16  excitation sample to the string stage.
REQ-013 noise_en  output  1  selects load mode in the string stage.
REQ-014 noise_pulse  output  1  load strobe; the string stage shifts on its rising edge.
REQ-015 sel_nota  output  10  registered note tap select.
REQ-016 div_freq_in  output  32  registered pitch divider.
REQ-017 done  output  1  one-cycle pulse when loading completes.

Function
REQ-018 FSM states SHALL be IDLE, PULSE_H, PULSE_L, GUARD_W and PLAY.
REQ-019 pluck_ready SHALL be high only in IDLE and PLAY.
REQ-020 On accept the block SHALL capture pluck_sel, pluck_div and pluck_amp, clear the pulse counter, set noise_en high and enter PULSE_L.
REQ-021 The captured values SHALL appear on sel_nota and div_freq_in on the cycle after accept.
REQ-022 PULSE_L SHALL hold noise_pulse low for PULSE_LO cycles, then go to PULSE_H.
REQ-023 PULSE_H SHALL hold noise_pulse high for PULSE_HI cycles, then increment the pulse counter.
REQ-024 After incrementing, PULSE_H SHALL go to PULSE_L if count < LINE_LEN, else to GUARD_W.
REQ-025 Noise SHALL come from a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1; the all-zero state SHALL be unreachable.
REQ-026 The LFSR SHALL advance exactly once per pulse, on the clk edge where noise_pulse falls high-to-low.
REQ-027 noise SHALL be constant across every rising edge of noise_pulse and for PULSE_HI cycles after it.
REQ-028 noise SHALL be a registered output; it SHALL equal the sign-preserving shift LFSR>>>amp.
REQ-029 Exactly LINE_LEN rising edges of noise_pulse SHALL occur per pluck.
REQ-030 GUARD_W SHALL hold noise_pulse low and noise_en high for GUARD cycles, then drop noise_en, pulse done for one cycle and enter PLAY.
REQ-031 noise_en SHALL change only while noise_pulse is low, so the downstream clock mux is glitch-free.
REQ-032 PLAY SHALL hold noise_en and noise_pulse low, hold sel_nota and div_freq_in, and accept a new pluck (retrigger) identically to IDLE.
REQ-033 pluck_valid outside IDLE/PLAY SHALL be ignored and not queued.
REQ-034 The LFSR SHALL NOT reset between plucks; consecutive plucks SHALL use different noise.
REQ-035 The pulse counter SHALL be ceil(log2(LINE_LEN+1)) bits wide and SHALL NOT wrap within a pluck.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, noise_en=0, noise_pulse=0, done=0, noise=0, sel_nota=0, div_freq_in=0, counters=0 and LFSR=16'hACE1.
REQ-037 Reset asserted mid-load SHALL abort the load; after release the block is in IDLE, pluck_ready=1, and no further pulses occur.

Verification
REQ-038 Reset, then pluck sel=10'd99, div=32'd1000, amp=0 -> exactly 700 noise_pulse rising edges, first noise=16'hACE1, done 1 cycle, sel_nota=99, div_freq_in=1000.
REQ-039 Pluck with amp=2 -> every sampled noise value equals reference LFSR>>>2; noise is never 0 before shift.
REQ-040 Assert pluck_valid during PULSE_H -> pluck_ready=0, no capture; pulse count stays 700.
REQ-041 Retrigger in PLAY with sel=10'd50 -> noise_en rises only while noise_pulse=0; second pluck noise sequence continues the LFSR, not the seed.
REQ-042 Drop rst_n after pulse 300 -> outputs zero asynchronously; after release, no pulses until a new accept.
REQ-043 LINE_LEN=3, PULSE_HI=1, PULSE_LO=1, GUARD=1 -> noise_en high for exactly 3*2+1+1 cycles after accept; done follows.

Source files
------------

// File: rtl/ks_pluck_ctrl.sv
// Karplus-Strong pluck controller: loads LINE_LEN LFSR noise words into the string
// delay line with a strobe, then hands the string over to playback.
//
// state   | meaning
// IDLE    | after reset, waiting for a pluck
// PULSE_L | noise_pulse low phase of one load strobe
// PULSE_H | noise_pulse high phase; string stage shifted on its rise
// GUARD_W | all words loaded, noise_en held so the clock mux settles
// PLAY    | string free-running; a new pluck retriggers
module ks_pluck_ctrl #(
  parameter int LINE_LEN = 700,
  parameter int PULSE_HI = 2,
  parameter int PULSE_LO = 2,
  parameter int GUARD    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pluck_valid,
  output logic        pluck_ready,
  input  logic [9:0]  pluck_sel,
  input  logic [31:0] pluck_div,
  input  logic [1:0]  pluck_amp,
  output logic [15:0] noise,
  output logic        noise_en,
  output logic        noise_pulse,
  output logic [9:0]  sel_nota,
  output logic [31:0] div_freq_in,
  output logic        done
);

  localparam int CW = $clog2(LINE_LEN + 1);
  localparam int TW = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {IDLE, PULSE_L, PULSE_H, GUARD_W, PLAY} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [15:0]     lfsr_q, lfsr_d, lfsr_step;
  logic [1:0]      amp_q, amp_d;
  logic [15:0]     noise_q, noise_d;
  logic [9:0]      sel_q, sel_d;
  logic [31:0]     div_q, div_d;
  logic            noise_en_q, noise_en_d;
  logic            noise_pulse_q, noise_pulse_d;
  logic            done_q, done_d;
  logic            accept, upd_noise;

  assign pluck_ready = (state_q == IDLE) || (state_q == PLAY);
  assign accept      = pluck_valid && pluck_ready;
  assign cnt_inc     = cnt_q + CW'(1);
  assign lfsr_step   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    amp_d     = amp_q;
    sel_d     = sel_q;
    div_d     = div_q;
    noise_d   = noise_q;
    done_d    = 1'b0;
    upd_noise = 1'b0;

    case (state_q)
      IDLE, PLAY: begin
        if (accept) begin
          sel_d     = pluck_sel;
          div_d     = pluck_div;
          amp_d     = pluck_amp;
          cnt_d     = '0;
          tmr_d     = TW'(PULSE_LO - 1);
          state_d   = PULSE_L;
          upd_noise = 1'b1;
        end
      end
      PULSE_L: begin
        if (tmr_q == '0) begin
          tmr_d   = TW'(PULSE_HI - 1);
          state_d = PULSE_H;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      PULSE_H: begin
        if (tmr_q == '0) begin
          // LFSR and noise step on the strobe's falling edge, so the word is
          // stable for the whole next low/high period.
          lfsr_d    = lfsr_step;
          upd_noise = 1'b1;
          cnt_d     = cnt_inc;
          if (cnt_inc < CW'(LINE_LEN)) begin
            tmr_d   = TW'(PULSE_LO - 1);
            state_d = PULSE_L;
          end else begin
            tmr_d   = TW'(GUARD);
            state_d = GUARD_W;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      GUARD_W: begin
        // One settle cycle after the last falling strobe, then GUARD cycles.
        if (tmr_q == '0) begin
          done_d  = 1'b1;
          state_d = PLAY;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (upd_noise) noise_d = 16'($signed(lfsr_d) >>> amp_d);

    noise_pulse_d = (state_d == PULSE_H);
    noise_en_d    = (state_d == PULSE_L) || (state_d == PULSE_H) || (state_d == GUARD_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      cnt_q         <= '0;
      lfsr_q        <= LFSR_SEED;
      amp_q         <= '0;
      noise_q       <= '0;
      sel_q         <= '0;
      div_q         <= '0;
      noise_en_q    <= 1'b0;
      noise_pulse_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      amp_q         <= amp_d;
      noise_q       <= noise_d;
      sel_q         <= sel_d;
      div_q         <= div_d;
      noise_en_q    <= noise_en_d;
      noise_pulse_q <= noise_pulse_d;
      done_q        <= done_d;
    end
  end

  assign noise       = noise_q;
  assign noise_en    = noise_en_q;
  assign noise_pulse = noise_pulse_q;
  assign sel_nota    = sel_q;
  assign div_freq_in = div_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ks_pluck_ctrl.sv
// Directed bench for ks_pluck_ctrl: expected noise words are queued at each
// accept from a reference LFSR and popped on every noise_pulse rising edge.
module tb_ks_pluck_ctrl;

  localparam int LL     = 700;
  localparam int EN_CYC = LL * (2 + 2) + 4 + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pluck_valid;
  logic        pluck_ready;
  logic [9:0]  pluck_sel;
  logic [31:0] pluck_div;
  logic [1:0]  pluck_amp;
  logic [15:0] noise;
  logic        noise_en, noise_pulse, done;
  logic [9:0]  sel_nota;
  logic [31:0] div_freq_in;

  logic        sm_valid, sm_ready, sm_en, sm_pulse, sm_done;
  logic [15:0] sm_noise;
  logic [9:0]  sm_sel;
  logic [31:0] sm_div;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rise_cnt = 0;
  int          en_cnt = 0;
  bit          mon_on = 1'b0;
  logic        prev_pulse = 1'b0;
  logic        prev_en = 1'b0;
  logic [15:0] ref_lfsr = 16'hACE1;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ks_pluck_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .pluck_valid(pluck_valid), .pluck_ready(pluck_ready),
    .pluck_sel(pluck_sel), .pluck_div(pluck_div), .pluck_amp(pluck_amp),
    .noise(noise), .noise_en(noise_en), .noise_pulse(noise_pulse),
    .sel_nota(sel_nota), .div_freq_in(div_freq_in), .done(done)
  );

  ks_pluck_ctrl #(.LINE_LEN(3), .PULSE_HI(1), .PULSE_LO(1), .GUARD(1)) u_sm (
    .clk(clk), .rst_n(rst_n), .pluck_valid(sm_valid), .pluck_ready(sm_ready),
    .pluck_sel(10'd1), .pluck_div(32'd2), .pluck_amp(2'd0),
    .noise(sm_noise), .noise_en(sm_en), .noise_pulse(sm_pulse),
    .sel_nota(sm_sel), .div_freq_in(sm_div), .done(sm_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] l);
    if (l[0]) return (l >> 1) ^ 16'hB400;
    return l >> 1;
  endfunction

  task automatic push_pluck(input logic [1:0] amp);
    logic signed [15:0] s;
    for (int i = 0; i < LL; i++) begin
      s = ref_lfsr;
      exp_q.push_back(16'(s >>> amp));
      ref_lfsr = ref_next(ref_lfsr);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (noise_pulse && !prev_pulse) begin
        rise_cnt++;
        chk("pulse_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("noise", noise, exp_q.pop_front());
      end
      if (noise_en) en_cnt++;
      if (noise_en !== prev_en) chk("en_edge_pulse_low", {prev_pulse, noise_pulse}, 0);
    end
    prev_pulse = noise_pulse;
    prev_en    = noise_en;
  end

  task automatic start_pluck(input logic [9:0] sel, input logic [31:0] div, input logic [1:0] amp);
    @(negedge clk);
    chk("ready_before", pluck_ready, 1);
    pluck_valid = 1'b1;
    pluck_sel   = sel;
    pluck_div   = div;
    pluck_amp   = amp;
    rise_cnt    = 0;
    en_cnt      = 0;
    push_pluck(amp);
    @(posedge clk);
    #1;
    pluck_valid = 1'b0;
    pluck_sel   = 10'($urandom);
    pluck_div   = $urandom;
    pluck_amp   = 2'($urandom);
    @(negedge clk);
    chk("sel_nota_cap", sel_nota, sel);
    chk("div_cap", div_freq_in, div);
    chk("en_after_accept", noise_en, 1);
    chk("ready_busy", pluck_ready, 0);
  endtask

  task automatic run_pluck(input logic [9:0] sel, input logic [31:0] div, input logic [1:0] amp,
                           input bit poke);
    bit seen;
    start_pluck(sel, div, amp);
    if (poke) begin
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (rise_cnt >= 100 && noise_pulse) begin seen = 1'b1; break; end
      end
      chk("reach_pulse_h", seen, 1);
      pluck_valid = 1'b1;
      pluck_sel   = ~sel;
      pluck_div   = ~div;
      chk("ready_in_pulse_h", pluck_ready, 0);
      @(posedge clk);
      #1;
      pluck_valid = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_seen", seen, 1);
    chk("rise_count", rise_cnt, LL);
    chk("en_cycles", en_cnt, EN_CYC);
    chk("queue_drained", exp_q.size(), 0);
    chk("en_low_at_done", noise_en, 0);
    chk("sel_nota_hold", sel_nota, sel);
    chk("div_hold", div_freq_in, div);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("ready_play", pluck_ready, 1);
  endtask

  initial begin
    bit seen;
    int n;
    rst_n       = 1'b0;
    pluck_valid = 1'b0;
    pluck_sel   = '0;
    pluck_div   = '0;
    pluck_amp   = '0;
    sm_valid    = 1'b0;
    #12;
    chk("rst_noise_en", noise_en, 0);
    chk("rst_pulse", noise_pulse, 0);
    chk("rst_noise", noise, 0);
    chk("rst_sel", sel_nota, 0);
    chk("rst_div", div_freq_in, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("ready_idle", pluck_ready, 1);

    run_pluck(10'd99, 32'd1000, 2'd0, 1'b1);
    run_pluck(10'd7, 32'h1234_5678, 2'd2, 1'b0);
    run_pluck(10'd50, 32'd333, 2'd3, 1'b0);

    start_pluck(10'd200, 32'd9, 2'd1);
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rise_cnt >= 300 && noise_pulse) begin seen = 1'b1; break; end
    end
    chk("reach_pulse_300", seen, 1);
    mon_on = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_noise_en", noise_en, 0);
    chk("abort_pulse", noise_pulse, 0);
    chk("abort_noise", noise, 0);
    chk("abort_sel", sel_nota, 0);
    chk("abort_div", div_freq_in, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    ref_lfsr = 16'hACE1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    rise_cnt = 0;
    prev_pulse = noise_pulse;
    prev_en    = noise_en;
    mon_on = 1'b1;
    repeat (50) @(negedge clk);
    chk("no_pulse_after_abort", rise_cnt, 0);
    chk("ready_after_abort", pluck_ready, 1);
    run_pluck(10'd3, 32'd77, 2'd1, 1'b0);

    @(negedge clk);
    sm_valid = 1'b1;
    @(posedge clk);
    #1 sm_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sm_en) n++;
      else break;
    end
    chk("small_en_cycles", n, 3 * 2 + 1 + 1);
    chk("small_done", sm_done, 1);
    chk("small_sel", sm_sel, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
